// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// the load ResultSrc code and the memory-wait FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// One operand's forwarding select: the newest producer (Memory) wins over
// Writeback; x0 is never forwarded.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage core: forwarding, load-use,
// branch flush and a bounded memory-wait freeze. Build option: HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       result_src_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lw_stall;
  logic       mem_stall;

  mem_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_error_q, mem_error_d;

  hazard_fwd_unit u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_b)
  );

  assign lw_stall = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // The ready cycle itself still stalls; W captures the data on the next edge.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_error_d = mem_error_q;
    mem_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (mem_req_m && !mem_ready) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
          timer_d   = TMR_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          mem_stall = 1'b1;
          state_d   = IDLE;
          timer_d   = '0;
        end else if (timer_q < TMR_MAX) begin
          mem_stall = 1'b1;
          timer_d   = timer_q + TMR_W'(1);
        end else begin
          state_d     = ERR;
          timer_d     = '0;
          mem_error_d = 1'b1;
        end
      end
      ERR: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though they are combinational.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    if (reset) begin
      forward_ae = fwd_a;
      forward_be = fwd_b;
      stall_f    = mem_stall || (lw_stall && !pc_src_e);
      stall_d    = mem_stall || (lw_stall && !pc_src_e);
      stall_e    = mem_stall;
      stall_m    = mem_stall;
      flush_w    = mem_stall;
      flush_d    = !mem_stall && pc_src_e;
      flush_e    = !mem_stall && (pc_src_e || lw_stall);
    end
  end

  assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_EN
  logic [2:0]         cnt_hit;
  logic [3*CNT_W-1:0] cnt_flat;

  // flush_e is already masked by mem_stall, so it counts non-frozen flushes only.
  assign cnt_hit = {reset && mem_stall, flush_e, stall_f};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_hit[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
  end

  assign stall_cnt   = cnt_flat[0*CNT_W +: CNT_W];
  assign flush_cnt   = cnt_flat[1*CNT_W +: CNT_W];
  assign memwait_cnt = cnt_flat[2*CNT_W +: CNT_W];
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl with directed scenarios and a
// rule-level reference model (stall counting per access, saturating counters).
module tb_hazard_ctrl;

  localparam int T  = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
  logic [4:0]    rd_e = '0, rd_m = '0, rd_w = '0;
  logic [1:0]    result_src_e = '0;
  logic          reg_write_m = 1'b0, reg_write_w = 1'b0;
  logic          pc_src_e = 1'b0, mem_req_m = 1'b0, mem_ready = 1'b0;
  logic [1:0]    forward_ae, forward_be;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w, mem_error;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .result_src_e (result_src_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_req_m    (mem_req_m),
    .mem_ready    (mem_ready),
    .forward_ae   (forward_ae),
    .forward_be   (forward_be),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .mem_error    (mem_error),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .memwait_cnt  (memwait_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stall cycles already spent on the current access,
  // whether the abort cycle is in progress, the sticky error and counters.
  int m_waited = 0;
  bit m_abort  = 0;
  bit m_error  = 0;
  int m_cnt[3] = '{0, 0, 0};

  bit e_ms, e_lw, e_sf, e_fe;

  task automatic model_clear();
    m_waited = 0;
    m_abort  = 0;
    m_error  = 0;
    m_cnt    = '{0, 0, 0};
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (reg_write_m && rd_m != 0 && rd_m == src) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_mem_stall();
    if (m_abort) return 0;
    if (m_waited == 0) return mem_req_m && !mem_ready;
    if (mem_ready) return 1;
    return m_waited < T;
  endfunction

  function automatic int exp_cnt(input int idx);
`ifdef HAZARD_PERF_EN
    return m_cnt[idx];
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    logic [1:0] fa, fb;
    logic [3:0] st;
    logic [2:0] fl;
    e_ms = exp_mem_stall();
    e_lw = result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    e_sf = e_ms || (e_lw && !pc_src_e);
    e_fe = !e_ms && (pc_src_e || e_lw);
    fa = exp_fwd(rs1_e);
    fb = exp_fwd(rs2_e);
    st = {e_sf, e_sf, e_ms, e_ms};
    fl = {!e_ms && pc_src_e, e_fe, e_ms};
    if (!reset) begin
      fa = 2'b00; fb = 2'b00; st = 4'b0; fl = 3'b0;
      e_ms = 0; e_sf = 0; e_fe = 0;
    end
    check("fwd_a", forward_ae, fa);
    check("fwd_b", forward_be, fb);
    check("stalls_fdem", {stall_f, stall_d, stall_e, stall_m}, st);
    check("flushes_dew", {flush_d, flush_e, flush_w}, fl);
    check("mem_error", mem_error, m_error);
    check("stall_cnt", stall_cnt, exp_cnt(0));
    check("flush_cnt", flush_cnt, exp_cnt(1));
    check("memwait_cnt", memwait_cnt, exp_cnt(2));
  endtask

  task automatic model_update();
    if (!reset) begin
      model_clear();
      return;
    end
    if (e_sf && m_cnt[0] < CMAX) m_cnt[0]++;
    if (e_fe && m_cnt[1] < CMAX) m_cnt[1]++;
    if (e_ms && m_cnt[2] < CMAX) m_cnt[2]++;
    if (m_abort) begin
      m_abort = 0;
    end else if (m_waited == 0) begin
      m_waited = (mem_req_m && !mem_ready) ? 1 : 0;
    end else if (mem_ready) begin
      m_waited = 0;
    end else if (m_waited < T) begin
      m_waited++;
    end else begin
      m_waited = 0;
      m_abort  = 1;
      m_error  = 1;
    end
  endtask

  // Inputs are driven just after a rising edge; outputs checked on the falling edge.
  task automatic do_cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    result_src_e = 2'b00;
    {reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready} = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_clear();
    do_cycle();
    reset = 1'b1;
  endtask

  task automatic randomize_inputs(input int ready_odds);
    rs1_d = 5'($urandom_range(0, 3));
    rs2_d = 5'($urandom_range(0, 3));
    rs1_e = 5'($urandom_range(0, 3));
    rs2_e = 5'($urandom_range(0, 3));
    rd_e  = 5'($urandom_range(0, 3));
    rd_m  = 5'($urandom_range(0, 3));
    rd_w  = 5'($urandom_range(0, 3));
    result_src_e = 2'($urandom_range(0, 3));
    reg_write_m  = 1'($urandom_range(0, 1));
    reg_write_w  = 1'($urandom_range(0, 1));
    pc_src_e     = ($urandom_range(0, 3) == 0);
    mem_req_m    = ($urandom_range(0, 3) != 0);
    mem_ready    = ($urandom_range(0, ready_odds) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    // Reset held with random inputs: every output must stay quiet.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1);
      do_cycle();
    end
    clear_inputs();
    reset = 1'b1;
    do_cycle();

    // Forwarding priority.
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    #2 check("fwd_mem_prio", forward_ae, 2'b10);
    do_cycle();
    rd_m = 0;
    #2 check("fwd_wb_when_rdm0", forward_ae, 2'b01);
    do_cycle();
    clear_inputs();

    // Load-use, then the bubble reaches E.
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    #2 check("lw_stall_fdE", {stall_f, stall_d, flush_e}, 3'b111);
    do_cycle();
    result_src_e = 2'b00; rd_e = 0;
    #2 check("lw_stall_once", {stall_f, stall_d, flush_e}, 3'b000);
    do_cycle();
    result_src_e = 2'b01; rd_e = 0; rs1_d = 0; rs2_d = 0;
    #2 check("lw_rd0_nostall", {stall_f, flush_e}, 2'b00);
    do_cycle();

    // Branch over a load-use match.
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7; pc_src_e = 1;
    #2 check("branch_lw", {flush_d, flush_e, stall_f, stall_d}, 4'b1100);
    do_cycle();
    clear_inputs();

    // Zero-wait access and a 3-cycle wait.
    mem_req_m = 1; mem_ready = 1;
    #2 check("zero_wait", stall_m, 1'b0);
    do_cycle();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #2 check("memwait4_stall", {stall_m, flush_w}, 2'b11);
      do_cycle();
    end
    mem_req_m = 0; mem_ready = 0;
    #2 check("memwait4_release", stall_m, 1'b0);
    check("memwait4_noerr", mem_error, 1'b0);
    do_cycle();

    // Reset asserted mid-wait aborts immediately without error.
    mem_req_m = 1; mem_ready = 0;
    do_cycle();
    do_cycle();
    #2 reset = 1'b0;
    model_clear();
    #1 check("async_reset_stall", {stall_f, stall_m, flush_w}, 3'b000);
    do_cycle();
    mem_req_m = 0;
    reset = 1'b1;
    #2 check("async_reset_noerr", mem_error, 1'b0);
    do_cycle();
    do_cycle();

    // Timeout: exactly T stall cycles, then a sticky error.
    pulse_reset();
    mem_req_m = 1; mem_ready = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (!stall_m) break;
      cnt++;
      do_cycle();
    end
    check("timeout_stall_cycles", cnt, T);
    do_cycle();
    mem_req_m = 0;
    #2 check("timeout_error", mem_error, 1'b1);
    check("timeout_memwait_cnt", memwait_cnt, exp_cnt(2));
`ifdef HAZARD_PERF_EN
    check("timeout_memwait_16", memwait_cnt, 16);
`else
    check("memwait_cnt_tied0", memwait_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      do_cycle();
    end
    #2 check("error_sticky", mem_error, 1'b1);
    reset = 1'b0;
    model_clear();
    #1 check("error_cleared_by_reset", mem_error, 1'b0);
    do_cycle();
    reset = 1'b1;

    // Randomized phases with varying memory latency.
    for (int p = 0; p < 6; p++) begin
      int odds;
      odds = (p % 3 == 0) ? 1 : ((p % 3 == 1) ? 4 : 25);
      for (int i = 0; i < 250; i++) begin
        randomize_inputs(odds);
        do_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
